uart_tx_framed: RTL and testbench
=================================

// Module: uart_tx_framed
// PURPOSE
//  Parametrised buffered UART transmitter: byte FIFO, internal baud divider, configurable data
//  width, parity and stop bits. Replaces the fixed 8N1 buffer/baud/TX-control chain in the
//  USART send path. Callers push words into the FIFO; frames leave on Tx_Pin back-to-back.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency
//  BAUD        921600      line rate; DIV = (CLK_HZ + BAUD/2) / BAUD = 54 at defaults
//  DATA_BITS   8           data bits per frame, 5..9
//  PARITY      0           0 = none, 1 = odd, 2 = even
//  STOP_BITS   1           1 or 2
//  FIFO_DEPTH  16          FIFO entries, power of 2, >= 2
// PORTS
//  CLOCK_50M    in   1                    sole clock
//  RST          in   1                    synchronous, active-high reset
//  Wr_En        in   1                    push Wr_Data when Full == 0
//  Wr_Data      in   DATA_BITS            word to send, LSB first on line
//  Flush        in   1                    drop all queued words; the frame in flight completes
//  Full         out  1                    FIFO full; a write is ignored
//  Empty        out  1                    FIFO empty
//  Fifo_Count   out  $clog2(FIFO_DEPTH)+1 occupancy
//  Overflow     out  1                    1-cycle pulse: Wr_En while Full
//  Busy         out  1                    FSM not IDLE
//  Tx_Done_Sig  out  1                    1-cycle pulse at the end of the last stop bit
//  Tx_Pin       out  1                    serial line, idle high, registered
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset values:
//   Tx_Pin = 1, Full = 0, Empty = 1, Fifo_Count = 0, Overflow = 0, Busy = 0, Tx_Done_Sig = 0.
//   FIFO pointers cleared. Baud counter cleared.
//   RST asserted mid-frame aborts the frame; Tx_Pin is high the cycle after.
//  FIFO:
//   - Write accepted iff Wr_En && !Full (Full sampled before a same-cycle pop).
//   - Simultaneous accepted write and pop leaves the count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - Flush has priority over write; the same-cycle write is discarded.
//  FSM states:
//   IDLE:   if !Empty, pop, load shift register, compute parity -> START.
//   START:  Tx_Pin = 0 for DIV clocks -> DATA.
//   DATA:   DATA_BITS bits, LSB first, DIV clocks each -> PARITY if PARITY != 0, else STOP.
//   PARITY: odd means ones(data) + parity bit is odd; even means that total is even -> STOP.
//   STOP:   Tx_Pin = 1 for STOP_BITS * DIV clocks. At the end, Tx_Done_Sig pulses.
//           If !Empty, go directly to START with the next word (no idle gap); else -> IDLE.
//  Baud counter: counts 0..DIV-1; restarts at every state entry, so no fractional drift
//   across frames.
//  Latency: a write accepted at edge N into an empty FIFO while IDLE gives Tx_Pin low
//   after edge N+2.
//  Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV clocks.
// STRUCTURE
//  Package uart_pkg:
//   PARITY_NONE/ODD/EVEN constants; function baud_div(clk_hz, baud).
//   FSM state encoding: IDLE, START, DATA, PARITY, STOP.
//  Sub-module uart_tx_fifo:
//   Synchronous FIFO parametrised on WIDTH and DEPTH, with flush, count, full and empty.
//   The FSM, baud counter and shift register stay in this module.
// TESTING
//  1. Defaults, write 0x55 -> Tx_Pin pattern 0,1,0,1,0,1,0,1,0,1, each bit 54 clocks;
//     Tx_Done_Sig pulses after 540 clocks.
//  2. PARITY=2, write 0x07 -> parity bit 1; PARITY=1, write 0x07 -> parity bit 0;
//     PARITY=1, write 0x00 -> parity bit 1.
//  3. Writes 0xA5 and 0x3C on consecutive cycles -> second start bit follows the first stop bit
//     with zero idle clocks; Busy stays 1 throughout.
//  4. Hold the FSM busy, write 17 words -> Full after 16 (Fifo_Count = 16);
//     the 17th write gives an Overflow pulse and is not queued.
//  5. Assert RST mid-DATA -> Tx_Pin = 1, Empty = 1, Busy = 0 the next cycle;
//     the next write transmits cleanly.
//  6. STOP_BITS=2, DATA_BITS=7, Flush with 3 words queued -> the current frame ends with
//     108 high clocks; the queued words are never sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART transmitter: parity modes, FSM
// state encoding and the baud divider calculation.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Rounded integer divider so the bit period error stays under half a clock.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO with flush, occupancy count, full/empty flags and a
// registered overflow pulse for writes attempted while full.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             push, pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    // Flush wins over both ports; full is judged before any same-cycle pop.
    assign push = wr_en_i && !full_o && !flush_i;
    assign pop  = rd_en_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = wr_en_i && full_o;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: FIFO feeding a framing FSM with its own baud
// counter; frames with configurable data width, parity and stop bits.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 921600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLOCK_50M,
    input  logic                          RST,
    input  logic                          Wr_En,
    input  logic [DATA_BITS-1:0]          Wr_Data,
    input  logic                          Flush,
    output logic                          Full,
    output logic                          Empty,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
    output logic                          Overflow,
    output logic                          Busy,
    output logic                          Tx_Done_Sig,
    output logic                          Tx_Pin
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int BW  = $clog2(DIV + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 bit_end;
    logic                 load_ok;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == PARITY_ODD) ? ~^d : ^d;
    endfunction

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLOCK_50M),
        .rst_i      (RST),
        .wr_en_i    (Wr_En),
        .wr_data_i  (Wr_Data),
        .rd_en_i    (pop),
        .flush_i    (Flush),
        .rd_data_o  (fifo_data),
        .full_o     (Full),
        .empty_o    (fifo_empty),
        .count_o    (Fifo_Count),
        .overflow_o (Overflow)
    );

    assign Empty       = fifo_empty;
    assign Busy        = (state_q != ST_IDLE);
    assign Tx_Done_Sig = done_q;
    assign Tx_Pin      = tx_q;

    assign bit_end = (baud_q == BAUD_LAST);
    // A word being flushed this cycle must not be started either.
    assign load_ok = !fifo_empty && !Flush;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (load_ok) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    par_d   = parity_bit(fifo_data);
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // Chain straight into the next start bit when work is queued.
                        if (load_ok) begin
                            pop     = 1'b1;
                            shift_d = fifo_data;
                            par_d   = parity_bit(fifo_data);
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the current state, so the pin lags the FSM by one clock.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50M) begin
        if (RST) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge CLOCK_50M) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: four configurations share one clock and reset;
// expected words go to a scoreboard on write and are matched against decoded frames.
module tb_uart_tx_framed;

    localparam int DIV_T = 54;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       par;
    } exp_t;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       par;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    logic       a_wr_en, a_flush, a_full, a_empty, a_ovf, a_busy, a_done, a_tx;
    logic [7:0] a_wr_data;
    logic [4:0] a_cnt;
    logic       b_wr_en, b_flush, b_full, b_empty, b_ovf, b_busy, b_done, b_tx;
    logic [7:0] b_wr_data;
    logic [4:0] b_cnt;
    logic       c_wr_en, c_flush, c_full, c_empty, c_ovf, c_busy, c_done, c_tx;
    logic [7:0] c_wr_data;
    logic [4:0] c_cnt;
    logic       d_wr_en, d_flush, d_full, d_empty, d_ovf, d_busy, d_done, d_tx;
    logic [6:0] d_wr_data;
    logic [4:0] d_cnt;

    uart_tx_framed u_a (
        .CLOCK_50M(clk), .RST(rst), .Wr_En(a_wr_en), .Wr_Data(a_wr_data), .Flush(a_flush),
        .Full(a_full), .Empty(a_empty), .Fifo_Count(a_cnt), .Overflow(a_ovf),
        .Busy(a_busy), .Tx_Done_Sig(a_done), .Tx_Pin(a_tx));

    uart_tx_framed #(.PARITY(2)) u_b (
        .CLOCK_50M(clk), .RST(rst), .Wr_En(b_wr_en), .Wr_Data(b_wr_data), .Flush(b_flush),
        .Full(b_full), .Empty(b_empty), .Fifo_Count(b_cnt), .Overflow(b_ovf),
        .Busy(b_busy), .Tx_Done_Sig(b_done), .Tx_Pin(b_tx));

    uart_tx_framed #(.PARITY(1)) u_c (
        .CLOCK_50M(clk), .RST(rst), .Wr_En(c_wr_en), .Wr_Data(c_wr_data), .Flush(c_flush),
        .Full(c_full), .Empty(c_empty), .Fifo_Count(c_cnt), .Overflow(c_ovf),
        .Busy(c_busy), .Tx_Done_Sig(c_done), .Tx_Pin(c_tx));

    uart_tx_framed #(.DATA_BITS(7), .STOP_BITS(2)) u_d (
        .CLOCK_50M(clk), .RST(rst), .Wr_En(d_wr_en), .Wr_Data(d_wr_data), .Flush(d_flush),
        .Full(d_full), .Empty(d_empty), .Fifo_Count(d_cnt), .Overflow(d_ovf),
        .Busy(d_busy), .Tx_Done_Sig(d_done), .Tx_Pin(d_tx));

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic int nbits(input int k);
        return (k == 3) ? 7 : 8;
    endfunction
    function automatic int haspar(input int k);
        return (k == 1 || k == 2) ? 1 : 0;
    endfunction
    function automatic int nstop(input int k);
        return (k == 3) ? 2 : 1;
    endfunction
    function automatic logic pin(input int k);
        case (k)
            0: return a_tx;
            1: return b_tx;
            2: return c_tx;
            default: return d_tx;
        endcase
    endfunction
    function automatic logic done_of(input int k);
        case (k)
            0: return a_done;
            1: return b_done;
            2: return c_done;
            default: return d_done;
        endcase
    endfunction
    function automatic logic busy_of(input int k);
        case (k)
            0: return a_busy;
            1: return b_busy;
            2: return c_busy;
            default: return d_busy;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req)
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
        else
            n_pass++;
    endtask

    // Drive one write for a single cycle starting at a falling edge.
    task automatic wr(input int k, input logic [8:0] d, input logic p, input bit push);
        exp_t e;
        case (k)
            0: begin a_wr_en = 1'b1; a_wr_data = d[7:0]; end
            1: begin b_wr_en = 1'b1; b_wr_data = d[7:0]; end
            2: begin c_wr_en = 1'b1; c_wr_data = d[7:0]; end
            default: begin d_wr_en = 1'b1; d_wr_data = d[6:0]; end
        endcase
        if (push) begin
            e.inst = k; e.data = d; e.par = p;
            sb.push_back(e);
        end
        @(negedge clk);
        a_wr_en = 1'b0; b_wr_en = 1'b0; c_wr_en = 1'b0; d_wr_en = 1'b0;
    endtask

    // Wait for a start bit, then compare every clock of the frame against the
    // scoreboard head; returns idle clocks before the start and Busy-low clocks.
    task automatic recv(input int k, output int wait_cyc, output int busy_low);
        exp_t        e;
        logic [15:0] bits;
        int          nb, nf, len, errs, done_at, done_cnt;
        wait_cyc = 0; busy_low = 0; errs = 0; done_at = -1; done_cnt = 0;
        @(negedge clk);
        while (pin(k) !== 1'b0 && wait_cyc < 2000) begin
            wait_cyc++;
            @(negedge clk);
        end
        check("start_seen", {31'd0, pin(k) === 1'b0}, 32'd1);
        if (pin(k) !== 1'b0) return;
        check("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("sb_inst", e.inst, k);
        nb   = nbits(k);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1 + i] = e.data[i];
        if (haspar(k) != 0) bits[1 + nb] = e.par;
        nf  = 1 + nb + haspar(k) + nstop(k);
        len = nf * DIV_T;
        for (int c = 0; c < len; c++) begin
            if (pin(k) !== bits[c / DIV_T]) errs++;
            if (done_of(k) === 1'b1) begin done_cnt++; done_at = c; end
            if (busy_of(k) !== 1'b1) busy_low++;
            if (c < len - 1) @(negedge clk);
        end
        check("frame_bits", errs, 0);
        check("done_pos", done_at, len - 1);
        check("done_cnt", done_cnt, 1);
    endtask

    task automatic quiet(input int k, input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (pin(k) !== 1'b1) lows++;
        end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   w, bl, lows;

        tbl[0] = '{0, 9'h055, 1'b0};
        tbl[1] = '{1, 9'h007, 1'b1};
        tbl[2] = '{2, 9'h007, 1'b0};
        tbl[3] = '{2, 9'h000, 1'b1};
        tbl[4] = '{1, 9'h0B3, 1'b1};
        tbl[5] = '{3, 9'h05A, 1'b0};

        rst = 1'b1;
        a_wr_en = 0; a_wr_data = 0; a_flush = 0;
        b_wr_en = 0; b_wr_data = 0; b_flush = 0;
        c_wr_en = 0; c_wr_data = 0; c_flush = 0;
        d_wr_en = 0; d_wr_data = 0; d_flush = 0;
        repeat (5) @(negedge clk);

        check("rst_tx", a_tx, 1);
        check("rst_full", a_full, 0);
        check("rst_empty", a_empty, 1);
        check("rst_count", a_cnt, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single frames from idle: pattern, parity, latency of two clocks.
        for (int i = 0; i < 6; i++) begin
            wr(tbl[i].inst, tbl[i].data, tbl[i].par, 1'b1);
            recv(tbl[i].inst, w, bl);
            check("latency", w, 1);
            check("busy_low", bl, 1);
            repeat (4) @(negedge clk);
        end

        // Back-to-back frames: no idle clock and Busy held across the boundary.
        wr(0, 9'h0A5, 1'b0, 1'b1);
        wr(0, 9'h03C, 1'b0, 1'b1);
        recv(0, w, bl);
        check("b2b_first_busy_low", bl, 0);
        recv(0, w, bl);
        check("b2b_gap", w, 0);
        check("b2b_second_busy_low", bl, 1);
        repeat (4) @(negedge clk);

        // Fill while the first frame holds the FSM; 18th write overflows.
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    wr(0, 9'(i * 7 + 3), 1'b0, i <= 16);
                    if (i == 16) begin
                        check("fill_full", a_full, 1);
                        check("fill_count", a_cnt, 16);
                        check("fill_no_ovf", a_ovf, 0);
                    end
                    if (i == 17) begin
                        check("ovf_pulse", a_ovf, 1);
                        check("ovf_count", a_cnt, 16);
                    end
                end
                @(negedge clk);
                check("ovf_one_cycle", a_ovf, 0);
            end
            begin
                int w2, b2;
                for (int f = 0; f < 17; f++) recv(0, w2, b2);
            end
        join
        quiet(0, 700, lows);
        check("ovf_word_not_sent", lows, 0);
        check("drain_empty", a_empty, 1);

        // Reset in the middle of the data bits with a second word queued.
        wr(0, 9'h0F0, 1'b0, 1'b1);
        wr(0, 9'h011, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", a_tx, 1);
        check("midrst_empty", a_empty, 1);
        check("midrst_busy", a_busy, 0);
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        wr(0, 9'h03C, 1'b0, 1'b1);
        recv(0, w, bl);
        check("post_rst_latency", w, 1);
        repeat (4) @(negedge clk);

        // Flush during a 7-bit, two-stop frame: frame completes, queue is dropped.
        fork
            begin
                int w3, b3;
                recv(3, w3, b3);
            end
            begin
                wr(3, 9'h04B, 1'b0, 1'b1);
                repeat (20) @(negedge clk);
                wr(3, 9'h011, 1'b0, 1'b1);
                wr(3, 9'h022, 1'b0, 1'b1);
                wr(3, 9'h033, 1'b0, 1'b1);
                check("flush_pre_count", d_cnt, 3);
                d_flush = 1'b1;
                d_wr_en = 1'b1;
                d_wr_data = 7'h44;
                @(negedge clk);
                d_flush = 1'b0;
                d_wr_en = 1'b0;
                sb.delete();
                check("flush_count", d_cnt, 0);
                check("flush_empty", d_empty, 1);
            end
        join
        quiet(3, 700, lows);
        check("flush_nothing_sent", lows, 0);
        check("flush_idle", d_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
